// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes and the control FSM states.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc_hi, acc_lo} pair: shift-add for multiply,
// restoring shift-subtract for divide, both through a single wide+1-bit adder.
module muldiv_step #(
    parameter int wide = 32
) (
    input  logic            div,
    input  logic [wide-1:0] acc_hi,
    input  logic [wide-1:0] acc_lo,
    input  logic [wide-1:0] opnd,
    output logic [wide-1:0] next_hi,
    output logic [wide-1:0] next_lo
);

    logic [wide:0]   x;
    logic [wide:0]   y;
    logic            cin;
    logic [wide+1:0] sum;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        x       = {1'b0, acc_hi};
        y       = '0;
        cin     = 1'b0;
        next_hi = acc_hi;
        next_lo = acc_lo;

        if (div) begin
            // Subtract as x + ~d + 1; the carry out of the top bit means x >= d.
            x   = {acc_hi, acc_lo[wide-1]};
            y   = ~{1'b0, opnd};
            cin = 1'b1;
        end else if (acc_lo[0]) begin
            y = {1'b0, opnd};
        end

        sum = {1'b0, x} + {1'b0, y} + {{(wide+1){1'b0}}, cin};

        if (div) begin
            if (sum[wide+1]) begin
                next_hi = sum[wide-1:0];
                next_lo = {acc_lo[wide-2:0], 1'b1};
            end else begin
                next_hi = x[wide-1:0];
                next_lo = {acc_lo[wide-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[wide:1];
            next_lo = {sum[0], acc_lo[wide-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: magnitudes are iterated in
// RUN, signs are restored in FIX, and MTHI/MTLO write HI/LO directly when idle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int wide = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [wide-1:0] a,
    input  logic [wide-1:0] b,
    input  logic            cancel,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [wide-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [wide-1:0] hi,
    output logic [wide-1:0] lo
);

    localparam int CW = $clog2(wide) + 1;

    state_e          state, state_next;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            iter_en;
    logic            write_result;
    logic            direct_ok;

    op_e             op_in;
    logic            sgn;
    logic [wide-1:0] mag_a, mag_b;

    logic [wide-1:0] acc_hi, acc_lo, opnd, a_raw;
    logic            is_div, neg_q, neg_r, b_zero;
    logic [wide-1:0] step_hi, step_lo;
    logic [2*wide-1:0] prod, prod_fix;
    logic [wide-1:0] res_hi, res_lo;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cancel)                 state_next = IDLE;
                else if (cnt == CW'(wide))  state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = cancel ? IDLE : DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign iter_en      = (state == RUN) && !cancel && (cnt != CW'(wide));
    assign write_result = (state == FIX) && !cancel;
    assign direct_ok    = (state == IDLE) || (state == DONE);

    assign op_in = op_e'(op);
    assign sgn   = op_is_signed(op_in);
    assign mag_a = (sgn && a[wide-1]) ? -a : a;
    assign mag_b = (sgn && b[wide-1]) ? -b : b;

    muldiv_step #(.wide(wide)) u_step (
        .div     (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .opnd    (opnd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // NOTE: the operand/accumulator registers are always loaded on accept
    // before being read, so they carry no reset and stay plain enable flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            a_raw  <= a;
            is_div <= op_is_div(op_in);
            neg_q  <= sgn && (a[wide-1] ^ b[wide-1]);
            neg_r  <= sgn && a[wide-1];
            b_zero <= (b == '0);
        end else if (iter_en) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        res_hi = prod_fix[2*wide-1:wide];
        res_lo = prod_fix[wide-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc_hi : acc_hi;
                res_lo = neg_q ? -acc_lo : acc_lo;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so later
    // statements (direct writes after the result) win without read/write races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept)       cnt <= '0;
            else if (iter_en) cnt <= cnt + CW'(1);

            if (write_result) begin
                hi          <= res_hi;
                lo          <= res_lo;
                div_by_zero <= is_div && b_zero;
            end
            if (direct_ok && we_hi) hi <= wd;
            if (direct_ok && we_lo) lo <= wd;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: each task drives one scenario and
// compares against hand-computed values.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wd = '0;
    logic        cancel = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    muldiv_unit #(.wide(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .cancel      (cancel),
        .we_hi       (we_hi),
        .we_lo       (we_lo),
        .wd          (wd),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    // Launches one operation and returns the number of edges from the
    // accept edge to the first cycle with done high (0 if it never came).
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int edges);
        @(negedge clk); op = o; a = x; b = y; start = 1'b1;
        @(negedge clk); start = 1'b0;
        edges = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_direct_write();
        we_hi = 1'b1; wd = 32'hCAFE_0001;
        @(negedge clk); we_hi = 1'b0; we_lo = 1'b1; wd = 32'hBEEF_0002;
        @(negedge clk); we_lo = 1'b0;
        checks++; if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi: got %h want %h", hi, 32'hCAFE_0001); end
        checks++; if (lo !== 32'hBEEF_0002) begin errors++; $display("FAIL mtlo: got %h want %h", lo, 32'hBEEF_0002); end
    endtask

    task automatic test_multu();
        int edges;
        @(negedge clk); op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b want 1", busy); end
        edges = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin edges = i; break; end
        end
        checks++; if (edges !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", edges); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want %h", lo, 32'h1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_signed();
        int edges;
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, edges);
        checks++; if (edges !== 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", edges); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h want %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, edges);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot: got %h want %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem: got %h want %h", hi, 32'hFFFF_FFFF); end
        do_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, edges);
        checks++; if ({hi, lo} !== 64'd30) begin errors++; $display("FAIL mult_negneg: got %h want %h", {hi, lo}, 64'd30); end
    endtask

    task automatic test_div_by_zero();
        int edges;
        do_op(OP_DIVU, 32'd100, 32'd0, edges);
        checks++; if (edges !== 34) begin errors++; $display("FAIL divz_latency: got %0d want 34", edges); end
        checks++; if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero: got %h want %h", {hi, lo}, {32'd100, 32'hFFFF_FFFF}); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divz_flag: got %b want 1", div_by_zero); end
        do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, edges);
        checks++; if ({hi, lo} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_zero_signed: got %h want %h", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end
    endtask

    task automatic test_div_overflow();
        int edges;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_minint: got %h want %h", {hi, lo}, {32'h0, 32'h8000_0000}); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_minint_flag: got %b want 0", div_by_zero); end
        do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        checks++; if ({hi, lo} !== {32'h8000_0000, 32'h0}) begin errors++; $display("FAIL divu_big: got %h want %h", {hi, lo}, {32'h8000_0000, 32'h0}); end
    endtask

    task automatic test_done_write_wins();
        int edges;
        do_op(OP_MULTU, 32'd6, 32'd7, edges);
        we_lo = 1'b1; wd = 32'h1234_5678;
        @(negedge clk); we_lo = 1'b0;
        checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL done_write_lo: got %h want %h", lo, 32'h1234_5678); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL done_write_hi: got %h want %h", hi, 32'h0); end
    endtask

    task automatic test_cancel();
        int edges;
        int d0;
        we_hi = 1'b1; wd = 32'h0000_AAAA;
        @(negedge clk); we_hi = 1'b0; we_lo = 1'b1; wd = 32'h0000_5555;
        @(negedge clk); we_lo = 1'b0;
        d0 = done_seen;
        op = OP_DIVU; a = 32'd50; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1; start = 1'b1;
        @(negedge clk); cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== {32'h0000_AAAA, 32'h0000_5555}) begin errors++; $display("FAIL cancel_keep: got %h want %h", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555}); end
        @(negedge clk); start = 1'b0;
        edges = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin edges = i; break; end
        end
        checks++; if (edges !== 34) begin errors++; $display("FAIL cancel_restart_latency: got %0d want 34", edges); end
        checks++; if ({hi, lo} !== {32'd1, 32'd7}) begin errors++; $display("FAIL cancel_restart_result: got %h want %h", {hi, lo}, {32'd1, 32'd7}); end
        @(negedge clk);
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL cancel_done_count: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_seen;
        @(negedge clk); op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk); start = 1'b0; we_hi = 1'b1; wd = 32'hDEAD_DEAD;
        @(negedge clk); we_hi = 1'b0;
        repeat (45) @(negedge clk);
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_seen - d0); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL busy_start_result: got %h want %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
    endtask

    task automatic test_reset_mid_op();
        int d0;
        d0 = done_seen;
        @(negedge clk); op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'h0000_0003; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst = 1'b0; cancel = 1'b1; we_hi = 1'b1; wd = 32'h5A5A_5A5A;
        @(negedge clk); rst = 1'b1; cancel = 1'b0; we_hi = 1'b0;
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        repeat (40) @(negedge clk);
        checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL midreset_done_count: got %0d want 0", done_seen - d0); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo_later: got %h want 0", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_direct_write();
        test_multu();
        test_signed();
        test_div_by_zero();
        test_div_overflow();
        test_done_write_wins();
        test_cancel();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
